// File: rtl/vga_plot_sink.sv
`timescale 1ns/1ps
// Plot-request sink: buffers (x, y, colour) requests, clips off-screen points and
// writes on-screen pixels to the framebuffer at y*WIDTH + x, honouring mem_busy.
module vga_plot_sink #(
  parameter int WIDTH    = 160,
  parameter int HEIGHT   = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int ADDR_W   = 15,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [X_W-1:0]      in_x,
  input  logic [Y_W-1:0]      in_y,
  input  logic [COLOUR_W-1:0] in_colour,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [COLOUR_W-1:0] mem_data,
  input  logic                mem_busy,
  output logic [15:0]         clip_count,
  output logic                frame_done
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]       FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [X_W:0]      X_LIM    = (X_W+1)'(WIDTH);
  localparam logic [Y_W:0]      Y_LIM    = (Y_W+1)'(HEIGHT);
  localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(WIDTH);
  localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(WIDTH*HEIGHT-1);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [X_W-1:0]      x_mem [DEPTH];
  logic [Y_W-1:0]      y_mem [DEPTH];
  logic [COLOUR_W-1:0] c_mem [DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [PW:0]         count;
  logic                alive;
  logic                full, empty, push, pop, adv_p1;

  logic [X_W-1:0]      x_p0;
  logic [Y_W-1:0]      y_p0;
  logic [COLOUR_W-1:0] c_p0;
  logic                inr_p0;
  logic [ADDR_W-1:0]   prod_p0;

  logic                vld_p1, inr_p1;
  logic [X_W-1:0]      x_p1;
  logic [COLOUR_W-1:0] c_p1;
  logic [ADDR_W-1:0]   prod_p1;

  logic                we_p2, done_p2;
  logic [ADDR_W-1:0]   addr_p2;
  logic [COLOUR_W-1:0] data_p2;
  logic [15:0]         clip_p2;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign in_ready = alive && !full;
  assign push     = in_valid && in_ready && !clear;
  assign adv_p1   = !we_p2 || !mem_busy;
  assign pop      = !empty && (!vld_p1 || adv_p1);

  // Stage 0: FIFO head, range check and row-offset product
  assign x_p0    = x_mem[rd_ptr];
  assign y_p0    = y_mem[rd_ptr];
  assign c_p0    = c_mem[rd_ptr];
  assign inr_p0  = ({1'b0, x_p0} < X_LIM) && ({1'b0, y_p0} < Y_LIM);
  assign prod_p0 = inr_p0 ? ADDR_W'(y_p0) * W_A : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      alive  <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + (PW+1)'(1);
          2'b01:   count <= count - (PW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      x_mem[wr_ptr] <= in_x;
      y_mem[wr_ptr] <= in_y;
      c_mem[wr_ptr] <= in_colour;
    end
  end

  // Stage 1: registered request with precomputed row offset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          vld_p1 <= 1'b0;
    else if (clear)      vld_p1 <= 1'b0;
    else if (pop)        vld_p1 <= 1'b1;
    else if (adv_p1)     vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      x_p1    <= x_p0;
      c_p1    <= c_p0;
      inr_p1  <= inr_p0;
      prod_p1 <= prod_p0;
    end
  end

  // Stage 2: framebuffer write port, clip counter and end-of-frame pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_p2   <= 1'b0;
      addr_p2 <= '0;
      data_p2 <= '0;
      clip_p2 <= '0;
      done_p2 <= 1'b0;
    end else if (clear) begin
      we_p2   <= 1'b0;
      clip_p2 <= '0;
      done_p2 <= 1'b0;
    end else begin
      done_p2 <= we_p2 && !mem_busy && (addr_p2 == LAST_A);
      if (adv_p1) begin
        we_p2 <= vld_p1 && inr_p1;
        if (vld_p1 && inr_p1) begin
          addr_p2 <= prod_p1 + ADDR_W'(x_p1);
          data_p2 <= c_p1;
        end
        if (vld_p1 && !inr_p1) clip_p2 <= sat_inc(clip_p2);
      end
    end
  end

  assign mem_we     = we_p2;
  assign mem_addr   = addr_p2;
  assign mem_data   = data_p2;
  assign clip_count = clip_p2;
  assign frame_done = done_p2;

endmodule

// File: doc/vga_plot_sink.md
Name: vga_plot_sink

Overview:
- Receiving end of the pixel-coordinate stream produced by the x/y coordinate counters in the VGA drawing path.
- Accepts (x, y, colour) plot requests over a valid/ready handshake and buffers them in a small FIFO.
- Clips requests that fall outside the screen, converts in-range coordinates to a linear framebuffer address, and drives the framebuffer write port. Honours backpressure from that port.
- Reports the number of clipped pixels and pulses when the bottom-right pixel has been written.

Parameters:
- WIDTH, 160, screen width in pixels; valid x is 0..WIDTH-1.
- HEIGHT, 120, screen height in pixels; valid y is 0..HEIGHT-1.
- X_W, 8, width of the x coordinate.
- Y_W, 7, width of the y coordinate.
- COLOUR_W, 3, width of the colour field.
- ADDR_W, 15, framebuffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.
- DEPTH, 4, FIFO depth in entries; power of two, at least 2.

Ports:
- clk  input  1  system clock, all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush; active-high.
- in_valid  input  1  plot request present.
- in_ready  output  1  block can accept a request this cycle.
- in_x  input  X_W  request x coordinate.
- in_y  input  Y_W  request y coordinate.
- in_colour  input  COLOUR_W  request colour.
- mem_we  output  1  framebuffer write strobe (valid).
- mem_addr  output  ADDR_W  write address, y*WIDTH + x.
- mem_data  output  COLOUR_W  write data.
- mem_busy  input  1  framebuffer not ready; the current write is not taken this cycle.
- clip_count  output  16  saturating count of dropped out-of-range requests.
- frame_done  output  1  one-cycle pulse when the write for (WIDTH-1, HEIGHT-1) is taken.

Behaviour:
- Reset is asynchronous and active-low, on reset; the clock is clk.
- While reset is low:
  - FIFO is empty.
  - S1 is invalid.
  - mem_we=0, mem_addr=0, mem_data=0.
  - clip_count=0, frame_done=0.
  - in_ready=0.
- After reset is released, in_ready=1 from the first clock edge.
- Handshake:
  - A request is accepted on a rising edge where in_valid && in_ready.
  - in_ready = !full, computed from the registered occupancy.
  - When full, no push is taken, even if a pop happens in the same cycle.
  - Push and pop in the same cycle on a non-full, non-empty FIFO are both honoured; occupancy is unchanged.
- Pipeline (three registers): FIFO -> S1 -> output register.
- S1 stage:
  - S1 captures the FIFO head: x, y, colour, an in_range flag (x<WIDTH && y<HEIGHT), and the registered product y*WIDTH.
  - S1 advances when !mem_we || !mem_busy.
  - The FIFO pops into S1 when the FIFO is non-empty and S1 is empty or advancing.
- Output stage:
  - When S1 advances with in_range=1: at the same edge mem_we=1, mem_addr=product+x, mem_data=colour.
  - When S1 advances with in_range=0: no write is issued and clip_count increments, saturating at 16'hFFFF.
  - If S1 advances while empty, or with in_range=0, then mem_we=0 after the edge.
- Latency:
  - Request accepted at edge E0, with the block empty and mem_busy low.
  - Pop into S1 at E1.
  - mem_we high in the cycle after E2; a write is taken that cycle if mem_busy=0.
  - Sustained throughput is one pixel per cycle with no bubbles.
- Stall:
  - While mem_we && mem_busy, mem_we, mem_addr and mem_data hold stable.
  - S1 holds, the FIFO stops popping, and the FIFO keeps filling until full.
- frame_done:
  - Registered. High for exactly one cycle, the cycle after an edge where mem_we && !mem_busy && the write corresponds to x=WIDTH-1, y=HEIGHT-1.
  - A clipped request never asserts frame_done.
- Arithmetic: the product and the sum are computed at ADDR_W width; out-of-range coordinates never reach address arithmetic on the output.
- clear:
  - Synchronous. On an edge with clear=1, the FIFO is emptied, S1 is invalidated, mem_we=0, clip_count=0, frame_done=0.
  - A push attempted on that same edge is discarded.
  - clear overrides the stall.
- Reset mid-operation discards all buffered requests immediately, with no partial write.

Test Plan:
- Single request (x=3, y=2, colour=5), mem_busy=0 -> one mem_we pulse with mem_addr=323, mem_data=5, high in the cycle after E2; no other writes.
- Stream (0,0), (1,0) … (159,119), in_valid held, mem_busy=0 -> 19200 writes with consecutive addresses 0..19199; in_ready stays 1; frame_done pulses exactly once, the cycle after the addr-19199 write.
- Requests (160,0), (0,120), (255,127), (10,10) -> only one write (addr 1610); clip_count=3.
- mem_busy held high for 10 cycles while pushing continuously:
  - mem_we/mem_addr stay frozen.
  - in_ready falls after 4 accepts.
  - On release, all pixels are written in order with none lost or duplicated.
- clear asserted with the FIFO full and the output stalled -> next cycle mem_we=0, clip_count=0, in_ready=1; no buffered pixel is later written.
- reset pulsed low mid-stream -> all outputs go to 0 asynchronously; after release, a new request (5,5) writes addr 805 only.
